// File: rtl/vec_issue_sequencer.sv
// Purpose: sequences one OPIVV/OPIVX/OPIVI instruction into LANES-wide beats; VEC_SEQ_VMASK_EN adds v0 masking.
// Latency: first beat one cycle after accept, done one cycle after the last beat handshake.
// Backpressure: beat outputs hold while beat_valid && !beat_ready; instr_ready only when idle.
module vec_issue_sequencer #(
  parameter int LANES  = 4,
  parameter int MAX_VL = 32,
  parameter int VL_W   = $clog2(MAX_VL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  input  logic [31:0]       rs1_data,
  input  logic [VL_W-1:0]   vl,
  input  logic [MAX_VL-1:0] v0_mask,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [VL_W-1:0]   beat_idx,
  output logic [LANES-1:0]  beat_mask,
  output logic              beat_last,
  output logic [1:0]        opnd_sel,
  output logic [31:0]       scalar_op,
  output logic [4:0]        vd,
  output logic [4:0]        vs1,
  output logic [4:0]        vs2,
  output logic [5:0]        funct6,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [VL_W:0] MAXV = (VL_W + 1)'(MAX_VL);
  localparam logic [VL_W:0] STEP = (VL_W + 1)'(LANES);

  state_t          state, state_nx;
  logic [VL_W:0]   idx, vl_eff, vl_clamp, vl_ext;
  logic [2:0]      f3;
  logic            legal, accept, last_w;
  logic [1:0]      sel_nx;
  logic [31:0]     sc_nx;

`ifdef VEC_SEQ_VMASK_EN
  logic [MAX_VL-1:0] v0_q;
  logic              vm_q;
`endif

  assign f3       = instruction[14:12];
  assign legal    = (instruction[6:0] == 7'b1010111) &&
                    (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
  assign vl_ext   = {1'b0, vl};
  assign vl_clamp = (vl_ext > MAXV) ? MAXV : vl_ext;
  assign accept   = instr_valid && (state == IDLE);
  assign last_w   = (idx + STEP) >= vl_eff;
  assign beat_idx = idx[VL_W-1:0];

  always_comb begin
    sel_nx = 2'b00;
    sc_nx  = 32'h0;
    if (f3 == 3'b100) begin
      sel_nx = 2'b01;
      sc_nx  = rs1_data;
    end else if (f3 == 3'b011) begin
      sel_nx = 2'b10;
      sc_nx  = {{27{instruction[19]}}, instruction[19:15]};
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = (state == IDLE);
    beat_valid  = (state == RUN);
    beat_last   = (state == RUN) && last_w;
    done        = (state == DONE);
    case (state)
      IDLE: if (instr_valid && legal) state_nx = (vl_clamp == '0) ? DONE : RUN;
      RUN:  if (beat_ready && last_w) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tail mask from element position; optional v0 gating uses the accept-time snapshot.
  always_comb begin
    beat_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [VL_W:0]     pos;
      logic [MAX_VL-1:0] sh;
      pos = idx + (VL_W + 1)'(i);
      sh  = '0;
      beat_mask[i] = (state == RUN) && (pos < vl_eff);
`ifdef VEC_SEQ_VMASK_EN
      sh = v0_q >> pos;
      if (!vm_q) beat_mask[i] = beat_mask[i] && sh[0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      vl_eff    <= '0;
      err       <= 1'b0;
      opnd_sel  <= 2'b00;
      scalar_op <= 32'h0;
      vd        <= 5'h0;
      vs1       <= 5'h0;
      vs2       <= 5'h0;
      funct6    <= 6'h0;
`ifdef VEC_SEQ_VMASK_EN
      v0_q      <= '0;
      vm_q      <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      err   <= 1'b0;
      if (accept) begin
        err       <= !legal;
        idx       <= '0;
        vl_eff    <= vl_clamp;
        opnd_sel  <= sel_nx;
        scalar_op <= sc_nx;
        vd        <= instruction[11:7];
        vs1       <= instruction[19:15];
        vs2       <= instruction[24:20];
        funct6    <= instruction[31:26];
`ifdef VEC_SEQ_VMASK_EN
        v0_q      <= v0_mask;
        vm_q      <= instruction[25];
`endif
      end else if (state == RUN && beat_ready && !last_w) begin
        idx <= idx + STEP;
      end
    end
  end

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Directed plus randomized bench for vec_issue_sequencer; expected beats come from a per-element model.
module tb_vec_issue_sequencer;

  localparam int L = 4;
  localparam int MV = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [5:0]  vl = 6'h0;
  logic [31:0] v0_mask = 32'h0;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic [5:0]  beat_idx;
  logic [3:0]  beat_mask;
  logic        beat_last;
  logic [1:0]  opnd_sel;
  logic [31:0] scalar_op;
  logic [4:0]  vd, vs1, vs2;
  logic [5:0]  funct6;
  logic        done, err;

  int ncomp = 0;
  int nfail = 0;

  vec_issue_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .rs1_data(rs1_data), .vl(vl), .v0_mask(v0_mask),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_idx(beat_idx),
    .beat_mask(beat_mask), .beat_last(beat_last), .opnd_sel(opnd_sel),
    .scalar_op(scalar_op), .vd(vd), .vs1(vs1), .vs2(vs2), .funct6(funct6),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

`ifdef VEC_SEQ_VMASK_EN
  localparam bit VMASK_EN = 1'b1;
`else
  localparam bit VMASK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic vm, input logic [4:0] s2,
                                     input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d);
    return {f6, vm, s2, s1, f3, d, 7'b1010111};
  endfunction

  // Element e of beat k is active if it lies below vl_eff and, when masking applies, v0 has it set.
  function automatic logic [3:0] exp_mask(input int k, input int vle, input bit vm, input logic [31:0] v0);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < L; i++) begin
      int e;
      e = k * L + i;
      if (e < vle) m[i] = (vm || !VMASK_EN) ? 1'b1 : v0[e];
    end
    return m;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_bvalid"}, beat_valid, 0);
    chk({tag, "_blast"}, beat_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_idx"}, beat_idx, 0);
    chk({tag, "_mask"}, beat_mask, 0);
    chk({tag, "_sel"}, opnd_sel, 0);
    chk({tag, "_scalar"}, scalar_op, 0);
    chk({tag, "_regs"}, {vd, vs1, vs2, funct6}, 0);
  endtask

  // stall_beat: -1 random backpressure, -2 never stall, k>=0 hold ready low 3 cycles on beat k.
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs1, input logic [5:0] vlin,
                       input logic [31:0] v0, input int stall_beat);
    logic [2:0]  f3;
    bit          legal, rdy;
    int          vle, nb, stalls;
    logic [1:0]  esel;
    logic [31:0] esc;
    f3    = ins[14:12];
    legal = (ins[6:0] == 7'b1010111) && (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
    vle   = (int'(vlin) > MV) ? MV : int'(vlin);
    nb    = (vle + L - 1) / L;
    esel  = (f3 == 3'b100) ? 2'b01 : (f3 == 3'b011) ? 2'b10 : 2'b00;
    esc   = (f3 == 3'b100) ? rs1 : (f3 == 3'b011) ? 32'($signed(ins[19:15])) : 32'h0;

    chk("accept_ready", instr_ready, 1);
    instruction = ins; rs1_data = rs1; vl = vlin; v0_mask = v0; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instruction = $urandom; rs1_data = $urandom; vl = 6'($urandom); v0_mask = $urandom;

    if (!legal) begin
      chk("illegal_err", err, 1);
      chk("illegal_bvalid", beat_valid, 0);
      chk("illegal_done", done, 0);
      chk("illegal_ready", instr_ready, 1);
      step();
      chk("illegal_err_pulse", err, 0);
      chk("illegal_done2", done, 0);
      return;
    end
    chk("legal_err", err, 0);
    if (nb == 0) begin
      chk("vl0_done", done, 1);
      chk("vl0_bvalid", beat_valid, 0);
      chk("vl0_ready", instr_ready, 0);
      step();
      chk("vl0_done_pulse", done, 0);
      chk("vl0_ready2", instr_ready, 1);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      stalls = 0;
      for (int s = 0; s < 8; s++) begin
        chk("beat_valid", beat_valid, 1);
        chk("beat_idx", beat_idx, k * L);
        chk("beat_mask", beat_mask, exp_mask(k, vle, ins[25], v0));
        chk("beat_last", beat_last, (k == nb - 1));
        chk("run_ready", instr_ready, 0);
        chk("run_done", done, 0);
        chk("opnd_sel", opnd_sel, esel);
        chk("scalar_op", scalar_op, esc);
        chk("fields", {vd, vs1, vs2, funct6}, {ins[11:7], ins[19:15], ins[24:20], ins[31:26]});
        if (stall_beat == k) rdy = (stalls >= 3);
        else if (stall_beat == -1) rdy = (stalls >= 3) || ($urandom_range(0, 3) != 0);
        else rdy = 1'b1;
        beat_ready = rdy;
        step();
        if (rdy) break;
        stalls++;
      end
    end
    beat_ready = 1'b0;
    chk("end_done", done, 1);
    chk("end_bvalid", beat_valid, 0);
    chk("end_ready", instr_ready, 0);
    step();
    chk("end_done_pulse", done, 0);
    chk("end_ready2", instr_ready, 1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [2:0]  f3s [5];
    f3s[0] = 3'b000; f3s[1] = 3'b100; f3s[2] = 3'b011; f3s[3] = 3'b111; f3s[4] = 3'b010;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    step();
    chk_reset_state("post_reset");

    // vl=10 VV, no backpressure: 3 beats with 0011 tail.
    issue(mk(6'h00, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 6'd10, 32'h0, -2);

    // VI sign-extension, then VX scalar pass-through.
    ins = mk(6'h05, 1'b1, 5'd4, 5'b11101, 3'b011, 5'd6);
    instruction = ins; vl = 6'd4; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; instruction = 32'h0;
    chk("vi_sel", opnd_sel, 2'b10);
    chk("vi_scalar", scalar_op, 32'hFFFFFFFD);
    beat_ready = 1'b1;
    step();
    beat_ready = 1'b0;
    step();
    issue(mk(6'h01, 1'b1, 5'd7, 5'd8, 3'b100, 5'd9), 32'h1234, 6'd4, 32'h0, -2);

    // Backpressure on beat 1 of vl=8, then vl=0, illegal funct3, clamped vl=40.
    issue(mk(6'h02, 1'b1, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 6'd8, 32'h0, 1);
    issue(mk(6'h00, 1'b1, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 6'd0, 32'h0, -2);
    issue(mk(6'h00, 1'b1, 5'd1, 5'd2, 3'b111, 5'd3), 32'h0, 6'd8, 32'h0, -2);
    issue(mk(6'h03, 1'b1, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 6'd40, 32'h0, -2);

    // Reset while beat 1 of vl=16 is pending.
    instruction = mk(6'h04, 1'b1, 5'd5, 5'd6, 3'b100, 5'd7); rs1_data = 32'hCAFE; vl = 6'd16;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    beat_ready = 1'b1;
    step();
    chk("rst_beat1_idx", beat_idx, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    beat_ready = 1'b0;
    chk_reset_state("midrun_reset");
    step();
    chk("midrun_no_done", done, 0);
    chk("midrun_ready", instr_ready, 1);

    // v0 mask pattern with vm=0 and vm=1.
    issue(mk(6'h00, 1'b0, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 6'd8, 32'h0000_00A5, -2);
    issue(mk(6'h00, 1'b1, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 6'd8, 32'h0000_00A5, -2);

    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      ins[6:0] = ($urandom_range(0, 9) == 0) ? 7'b0110011 : 7'b1010111;
      ins[14:12] = f3s[$urandom_range(0, 4)];
      issue(ins, $urandom, 6'($urandom), $urandom, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
